// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//  - uart_state_t : common state encoding (the receiver uses ST_RESET as well)
//  - uart_err_t   : receiver error codes
//  - default frame constants and the parity helper
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int MAX_DATA_BITS      = 9;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_START_BIT,
    ST_DATA_BITS,
    ST_PARITY,
    ST_STOP_BIT
  } uart_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_FRAMING,
    ERR_PARITY,
    ERR_OVERRUN
  } uart_err_t;

  // Parity over a zero-extended data word. The extension bits are zero,
  // so they do not change the reduction result.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: OVERSAMPLE-modulo counter that marks the last clock of a bit.
//  clk      in  clock (OVERSAMPLE x baud)
//  srst     in  synchronous active-high reset
//  clear    in  force the count back to 0
//  run      in  count while high; held at 0 while low
//  bit_tick out high during the final clock of each bit period
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  assign bit_tick = run & (cnt_reg == TERMINAL);

  always_comb begin
    cnt_next = cnt_reg;
    if (clear || !run) begin
      cnt_next = '0;
    end else if (bit_tick) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises bytes into start / data (LSB first) / optional parity / stop frames.
//  tx_Clk      in  oversample clock (OVERSAMPLE x baud)
//  tx_Rst      in  synchronous active-high reset
//  enable      in  transmitter enable; low aborts any frame in progress
//  i_TX_byte   in  byte to send, captured on accept
//  i_TX_valid  in  source has a byte
//  o_TX_ready  out block can accept a byte this cycle
//  o_TX_serial out serial line, idle high
//  o_TX_active out frame in progress
//  o_TX_done   out one-cycle pulse when a frame completes normally
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 tx_Clk,
  input  logic                 tx_Rst,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] i_TX_byte,
  input  logic                 i_TX_valid,
  output logic                 o_TX_ready,
  output logic                 o_TX_serial,
  output logic                 o_TX_active,
  output logic                 o_TX_done
);

  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_t            state_reg, state_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic                   parity_reg, parity_next;
  logic                   serial_reg, serial_next;
  logic                   active_reg, active_next;
  logic                   ready_reg, ready_next;
  logic                   done_reg, done_next;

  logic [MAX_DATA_BITS-1:0] byte_ext;
  logic                     bit_tick;
  logic                     timer_run;

  // The timer idles at zero, so the first START clock is always count 0.
  assign timer_run = (state_reg != ST_IDLE);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk     (tx_Clk),
    .srst    (tx_Rst),
    .clear   (~enable),
    .run     (timer_run),
    .bit_tick(bit_tick)
  );

  always_comb begin
    byte_ext = '0;
    byte_ext[DATA_BITS-1:0] = i_TX_byte;
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    serial_next  = serial_reg;
    active_next  = active_reg;
    ready_next   = ready_reg;
    done_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        serial_next = 1'b1;
        active_next = 1'b0;
        ready_next  = enable;
        if (enable && ready_reg && i_TX_valid) begin
          shift_next   = i_TX_byte;
          parity_next  = parity_bit(byte_ext, PARITY_ODD != 0);
          bit_cnt_next = '0;
          state_next   = ST_START_BIT;
          serial_next  = 1'b0;
          active_next  = 1'b1;
          ready_next   = 1'b0;
        end
      end
      ST_START_BIT: begin
        if (bit_tick) begin
          state_next   = ST_DATA_BITS;
          serial_next  = shift_reg[0];
          bit_cnt_next = '0;
        end
      end
      ST_DATA_BITS: begin
        if (bit_tick) begin
          if (bit_cnt_reg == LAST_DATA) begin
            bit_cnt_next = '0;
            if (PARITY_EN != 0) begin
              state_next  = ST_PARITY;
              serial_next = parity_reg;
            end else begin
              state_next  = ST_STOP_BIT;
              serial_next = 1'b1;
            end
          end else begin
            // Bit 1 of the current word becomes bit 0 after the shift.
            shift_next   = shift_reg >> 1;
            serial_next  = shift_reg[1];
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_next   = ST_STOP_BIT;
          serial_next  = 1'b1;
          bit_cnt_next = '0;
        end
      end
      ST_STOP_BIT: begin
        if (bit_tick) begin
          if (bit_cnt_reg == LAST_STOP) begin
            state_next   = ST_IDLE;
            bit_cnt_next = '0;
            done_next    = 1'b1;
            active_next  = 1'b0;
            ready_next   = enable;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next  = ST_IDLE;
        serial_next = 1'b1;
        active_next = 1'b0;
        ready_next  = 1'b0;
      end
    endcase

    // Dropping enable truncates the frame at once and suppresses done.
    if (!enable) begin
      state_next   = ST_IDLE;
      bit_cnt_next = '0;
      serial_next  = 1'b1;
      active_next  = 1'b0;
      ready_next   = 1'b0;
      done_next    = 1'b0;
    end
  end

  always_ff @(posedge tx_Clk) begin
    if (tx_Rst) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
      serial_reg  <= 1'b1;
      active_reg  <= 1'b0;
      ready_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      parity_reg  <= parity_next;
      serial_reg  <= serial_next;
      active_reg  <= active_next;
      ready_reg   <= ready_next;
      done_reg    <= done_next;
    end
  end

  assign o_TX_ready  = ready_reg;
  assign o_TX_serial = serial_reg;
  assign o_TX_active = active_reg;
  assign o_TX_done   = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four transmitter configurations driven from one clock:
//  0: 8N1, 1: 8 data + odd parity, 2: 8 data + even parity, 3: 7 data, 2 stop.
// Expected line waveforms come from a frame model built from the bit list.
module tb_uart_tx;

  localparam int NCFG = 4;
  localparam int OS   = 16;
  localparam int DB[NCFG] = '{8, 8, 8, 7};
  localparam int PE[NCFG] = '{0, 1, 1, 0};
  localparam int PO[NCFG] = '{0, 1, 0, 0};
  localparam int SB[NCFG] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       valid   [NCFG];
  logic [8:0] byte_in [NCFG];
  logic       ready   [NCFG];
  logic       serial  [NCFG];
  logic       active  [NCFG];
  logic       done    [NCFG];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit exp_q[$];
  bit got_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < NCFG; gi++) begin : g_dut
      uart_tx #(
        .DATA_BITS (DB[gi]),
        .OVERSAMPLE(OS),
        .PARITY_EN (PE[gi]),
        .PARITY_ODD(PO[gi]),
        .STOP_BITS (SB[gi])
      ) dut (
        .tx_Clk     (clk),
        .tx_Rst     (rst),
        .enable     (enable),
        .i_TX_byte  (byte_in[gi][DB[gi]-1:0]),
        .i_TX_valid (valid[gi]),
        .o_TX_ready (ready[gi]),
        .o_TX_serial(serial[gi]),
        .o_TX_active(active[gi]),
        .o_TX_done  (done[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_bit(input bit b);
    for (int i = 0; i < OS; i++) exp_q.push_back(b);
  endfunction

  // Line waveform: start 0, data LSB first, parity so the count of ones
  // (data + parity) is even/odd, then stop bits high.
  function automatic void build_frame(input int c, input logic [8:0] d);
    int ones;
    ones = 0;
    exp_q.delete();
    push_bit(1'b0);
    for (int i = 0; i < DB[c]; i++) begin
      push_bit(d[i]);
      ones += int'(d[i]);
    end
    if (PE[c] != 0) push_bit(PO[c] != 0 ? (ones % 2 == 0) : (ones % 2 == 1));
    for (int s = 0; s < SB[c]; s++) push_bit(1'b1);
  endfunction

  // Called at the sample point right after the accept edge. Returns one
  // clock after the done cycle.
  task automatic check_frame(input int c, input int exp_len);
    int k, bad_ser, bad_ctl;
    k = 0; bad_ser = 0; bad_ctl = 0;
    got_q.delete();
    while (done[c] !== 1'b1 && k < 400) begin
      got_q.push_back(serial[c]);
      if (k >= exp_q.size() || serial[c] !== exp_q[k]) bad_ser++;
      if (active[c] !== 1'b1 || ready[c] !== 1'b0) bad_ctl++;
      step();
      k++;
    end
    chk($sformatf("cfg%0d serial_wave_bad_samples", c), bad_ser, 0);
    chk($sformatf("cfg%0d active_ready_in_frame_bad", c), bad_ctl, 0);
    chk($sformatf("cfg%0d frame_len", c), k, exp_len);
    chk($sformatf("cfg%0d done_cycle_serial", c), int'(serial[c]), 1);
    chk($sformatf("cfg%0d done_cycle_active", c), int'(active[c]), 0);
    chk($sformatf("cfg%0d done_cycle_ready", c), int'(ready[c]), 1);
    step();
    chk($sformatf("cfg%0d done_one_cycle", c), int'(done[c]), 0);
  endtask

  task automatic wait_ready(input int c, output bit ok);
    int n;
    n = 0;
    while (ready[c] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    ok = (ready[c] === 1'b1);
    if (!ok) chk($sformatf("cfg%0d ready_timeout", c), 0, 1);
  endtask

  task automatic send(input int c, input logic [8:0] d, input int exp_len);
    bit ok;
    wait_ready(c, ok);
    if (ok) begin
      byte_in[c] = d;
      valid[c] = 1'b1;
      step();
      valid[c] = 1'b0;
      byte_in[c] = 9'(d ^ 9'h1FF);
      build_frame(c, d);
      check_frame(c, exp_len);
      $display("cfg%0d byte 0x%02h sent, %0d clocks", c, d, got_q.size());
    end
  endtask

  typedef struct {
    int         cfg;
    logic [8:0] data;
    int         len;
    int         pidx;
    logic       pval;
  } vec_t;

  vec_t vt[6];

  initial begin
    bit ok;
    int t_start, drop_done;
    logic [8:0] d;

    vt[0] = '{0, 9'h0A5, 160, 24, 1'b1};
    vt[1] = '{0, 9'h000, 160, 8, 1'b0};
    vt[2] = '{1, 9'h003, 176, 152, 1'b1};
    vt[3] = '{2, 9'h003, 176, 152, 1'b0};
    vt[4] = '{3, 9'h07F, 160, 150, 1'b1};
    vt[5] = '{1, 9'h0FF, 176, 152, 1'b1};

    // Reset held 3 clocks with valid high.
    for (int c = 0; c < NCFG; c++) begin
      valid[c] = 1'b1;
      byte_in[c] = 9'h055;
    end
    rst = 1'b1;
    enable = 1'b1;
    for (int r = 0; r < 3; r++) begin
      step();
      for (int c = 0; c < NCFG; c++) begin
        chk($sformatf("cfg%0d rst_serial", c), int'(serial[c]), 1);
        chk($sformatf("cfg%0d rst_ready", c), int'(ready[c]), 0);
        chk($sformatf("cfg%0d rst_active", c), int'(active[c]), 0);
        chk($sformatf("cfg%0d rst_done", c), int'(done[c]), 0);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < NCFG; c++) valid[c] = 1'b0;
    step();
    chk("ready_after_rst", int'(ready[0]), 1);

    // Table-driven frames with a probe of one bit position.
    for (int v = 0; v < 6; v++) begin
      send(vt[v].cfg, vt[v].data, vt[v].len);
      chk($sformatf("vec%0d probe_bit_%0d", v, vt[v].pidx),
          (vt[v].pidx < got_q.size()) ? int'(got_q[vt[v].pidx]) : -1, int'(vt[v].pval));
    end

    // Random bytes on every configuration.
    for (int c = 0; c < NCFG; c++) begin
      for (int n = 0; n < 3; n++) begin
        d = 9'($urandom_range(0, (1 << DB[c]) - 1));
        send(c, d, (1 + DB[c] + PE[c] + SB[c]) * OS);
      end
    end

    // Back-to-back: 0x00 then 0xFF with valid held throughout.
    wait_ready(0, ok);
    if (ok) begin
      byte_in[0] = 9'h000;
      valid[0] = 1'b1;
      step();
      t_start = cyc;
      byte_in[0] = 9'h0FF;
      build_frame(0, 9'h000);
      check_frame(0, 160);
      valid[0] = 1'b0;
      chk("b2b_start_after_done", int'(serial[0]), 0);
      build_frame(0, 9'h0FF);
      check_frame(0, 160);
      chk("b2b_total_clks", cyc - t_start - 1, 321);
      $display("cfg0 back-to-back 0x00,0xFF: %0d clocks", cyc - t_start - 1);
    end

    // Enable dropped at clock 50 of a frame.
    wait_ready(0, ok);
    if (ok) begin
      byte_in[0] = 9'h05A;
      valid[0] = 1'b1;
      step();
      valid[0] = 1'b0;
      repeat (49) step();
      enable = 1'b0;
      step();
      chk("abort_serial", int'(serial[0]), 1);
      chk("abort_active", int'(active[0]), 0);
      chk("abort_ready", int'(ready[0]), 0);
      drop_done = 0;
      for (int i = 0; i < 200; i++) begin
        if (done[0] === 1'b1) drop_done++;
        step();
      end
      chk("abort_no_done", drop_done, 0);
      // Valid high while disabled must not start a frame.
      valid[0] = 1'b1;
      repeat (5) step();
      chk("disabled_no_accept", int'(active[0]), 0);
      valid[0] = 1'b0;
      enable = 1'b1;
      step();
      chk("reenable_ready", int'(ready[0]), 1);
      $display("cfg0 frame aborted at clock 50, re-enabled");
      send(0, 9'h03C, 160);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
